// File: rtl/openserdes_tx_scheduler.sv
// openserdes_tx_scheduler: round-robin scheduler sharing one serializer; define OPENSERDES_SCHED_TIMEOUT_EN for the SEND watchdog.
module openserdes_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 256,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]       REQ_ACK,
  output logic                     SER_READY,
  output logic [WIDTH-1:0]         SER_DATA,
  input  logic                     SER_COMPLETE,
  output logic [IW-1:0]            GRANT_ID,
  output logic                     BUSY,
  output logic                     FRAME_DONE,
  output logic                     TIMEOUT_ERR
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] last_q, last_d, gid_q, gid_d, pick;
  logic [GW-1:0] gap_q, gap_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic ready_q, ready_d, done_q, done_d, busy_q, busy_d, comp_q, found, rise, tmo;
  logic [WIDTH-1:0] words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign words[i] = REQ_DATA[WIDTH*i +: WIDTH];
  end

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NUM_REQ);
  endfunction

  // Round-robin search starting just after the previous winner, wrapping to 0.
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && REQ_VALID[rr_idx(last_q, k)]) begin
        found = 1'b1;
        pick = rr_idx(last_q, k);
      end
    end
  end

  assign rise = SER_COMPLETE & ~comp_q;

`ifdef OPENSERDES_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] to_q, to_d;
  logic err_q, err_d;
  // Watchdog: count SEND cycles; expire on the last allowed cycle without a completion edge.
  always_comb begin
    to_d = (state_q == SEND) ? to_q + TW'(1) : '0;
    tmo = (state_q == SEND) && !rise && (to_q == TW'(TIMEOUT_CYCLES - 1));
    err_d = err_q | tmo;
  end
  assign TIMEOUT_ERR = err_q;
`else
  // No watchdog: SEND waits for the completion edge indefinitely.
  assign tmo = 1'b0;
  assign TIMEOUT_ERR = tmo && (TIMEOUT_CYCLES > 0);
`endif

  // Next state and registered outputs for IDLE/SEND/GAP.
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gid_d = gid_q;
    gap_d = gap_q;
    ack_d = '0;
    ready_d = ready_q;
    data_d = data_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = SEND;
        last_d = pick;
        gid_d = pick;
        ack_d[pick] = 1'b1;
        ready_d = 1'b1;
        data_d = words[pick];
      end
      SEND: if (rise || tmo) begin
        state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        gap_d = GAP_LAST;
        ready_d = 1'b0;
        data_d = '0;
        done_d = rise;
      end
      GAP: begin
        state_d = (gap_q == '0) ? IDLE : GAP;
        gap_d = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; async reset aborts any frame in flight.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_REQ - 1);
      gid_q <= '0;
      gap_q <= '0;
      ack_q <= '0;
      ready_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      comp_q <= 1'b0;
`ifdef OPENSERDES_SCHED_TIMEOUT_EN
      to_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gid_q <= gid_d;
      gap_q <= gap_d;
      ack_q <= ack_d;
      ready_q <= ready_d;
      data_q <= data_d;
      done_q <= done_d;
      busy_q <= busy_d;
      comp_q <= SER_COMPLETE;
`ifdef OPENSERDES_SCHED_TIMEOUT_EN
      to_q <= to_d;
      err_q <= err_d;
`endif
    end
  end

  assign REQ_ACK = ack_q;
  assign SER_READY = ready_q;
  assign SER_DATA = data_q;
  assign GRANT_ID = gid_q;
  assign BUSY = busy_q;
  assign FRAME_DONE = done_q;
endmodule

// File: tb/tb_openserdes_tx_scheduler.sv
// tb_openserdes_tx_scheduler: directed and random checks of the TX scheduler against a frame-level model.
module tb_openserdes_tx_scheduler;
  localparam int N = 4;
  localparam int W = 256;
  localparam int GAP = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic ser_complete = 1'b0;
  logic [N-1:0] req_ack;
  logic ser_ready;
  logic [W-1:0] ser_data;
  logic [1:0] grant_id;
  logic busy, frame_done, timeout_err;

  logic [N-1:0] e_ack = '0;
  logic e_rdy = 1'b0;
  logic [W-1:0] e_data = '0;
  logic [1:0] e_gid = '0;
  logic e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int done_seen = 0;
  bit chk_en = 1'b0;

  openserdes_tx_scheduler #(
    .NUM_REQ(N), .WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(clk), .RESET(rst_n), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_ACK(req_ack), .SER_READY(ser_ready), .SER_DATA(ser_data),
    .SER_COMPLETE(ser_complete), .GRANT_ID(grant_id), .BUSY(busy),
    .FRAME_DONE(frame_done), .TIMEOUT_ERR(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int k = 0; k < W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    check(name, W'(busy), W'(0));
  endtask

  // Frame-level model: a frame owner, the cycle the link is free again, and the last winner.
  initial begin : model
    int cyc = 0, owner = -1, last = N - 1, free_at = 0, send_at = 0;
    logic prev_c = 1'b0, rise;
    logic [W-1:0] word = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        owner = -1; last = N - 1; free_at = 0; prev_c = 1'b0;
        e_ack = '0; e_rdy = 1'b0; e_data = '0; e_gid = '0;
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      end else begin
        cyc++;
        rise = ser_complete && !prev_c;
        prev_c = ser_complete;
        e_ack = '0;
        e_done = 1'b0;
        if (owner >= 0) begin
          if (rise) begin
            owner = -1; free_at = cyc + GAP + 1; e_done = 1'b1;
          end
`ifdef OPENSERDES_SCHED_TIMEOUT_EN
          else if (cyc - send_at >= TO) begin
            owner = -1; free_at = cyc + GAP + 1; e_err = 1'b1;
          end
`endif
        end else if (cyc >= free_at && req_valid != '0) begin
          for (int d = 1; d <= N && owner < 0; d++)
            if (req_valid[(last + d) % N]) owner = (last + d) % N;
          last = owner;
          send_at = cyc;
          word = req_data[W*owner +: W];
          e_ack[owner] = 1'b1;
          e_gid = 2'(owner);
        end
        e_rdy = (owner >= 0);
        e_data = (owner >= 0) ? word : '0;
        e_busy = (owner >= 0) || (cyc + 1 < free_at);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("ack", W'(req_ack), W'(e_ack));
        check("ready", W'(ser_ready), W'(e_rdy));
        check("data", ser_data, e_data);
        check("gid", W'(grant_id), W'(e_gid));
        check("busy", W'(busy), W'(e_busy));
        check("done", W'(frame_done), W'(e_done));
        check("terr", W'(timeout_err), W'(e_err));
      end
      if (frame_done === 1'b1) done_seen++;
    end
  end

  initial begin : drive
    logic [W-1:0] a5;
    int gap_len, base, n;
    a5 = {32{8'hA5}};
    chk_en = 1'b1;
    repeat (3) step();
    check("rst_ready", W'(ser_ready), W'(0));
    check("rst_data", ser_data, W'(0));
    check("rst_ack", W'(req_ack), W'(0));
    check("rst_gid", W'(grant_id), W'(0));
    check("rst_busy", W'(busy), W'(0));
    check("rst_terr", W'(timeout_err), W'(0));
    rst_n = 1'b1;
    // single requester 2 with the A5 pattern
    req_data = {rnd(), rnd(), rnd(), rnd()};
    req_data[W*2 +: W] = a5;
    req_valid = 4'b0100;
    step();
    check("a5_ack", W'(req_ack), W'(4'b0100));
    check("a5_model_ack", W'(e_ack), W'(4'b0100));
    check("a5_gid", W'(grant_id), W'(2));
    check("a5_model_gid", W'(e_gid), W'(2));
    check("a5_data", ser_data, a5);
    check("a5_ready", W'(ser_ready), W'(1));
    req_valid = '0;
    repeat (4) begin
      step();
      check("a5_hold_ready", W'(ser_ready), W'(1));
      check("a5_hold_data", ser_data, a5);
    end
    ser_complete = 1'b1;
    step();
    ser_complete = 1'b0;
    check("a5_done", W'(frame_done), W'(1));
    check("a5_ready_drop", W'(ser_ready), W'(0));
    // gap between FRAME_DONE and the next SER_READY rise
    req_data[0 +: W] = rnd();
    req_valid = 4'b0001;
    gap_len = 0;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (ser_ready === 1'b1) break;
      gap_len++;
    end
    check("gap_len", W'(gap_len), W'(2));
    req_valid = '0;
    ser_complete = 1'b1;
    step();
    ser_complete = 1'b0;
    wait_idle("gap_idle");
    // all four requesters held: grant order from reset
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    req_data = {rnd(), rnd(), rnd(), rnd()};
    req_valid = 4'hF;
    base = done_seen;
    for (int f = 0; f < 8; f++) begin
      n = 0;
      while (req_ack === '0 && n < 20) begin
        step();
        n++;
      end
      check($sformatf("rr_ack%0d", f), W'(req_ack), W'(4'b0001 << (f % N)));
      check($sformatf("rr_grant%0d", f), W'(grant_id), W'(f % N));
      if (f == 7) req_valid = '0;
      ser_complete = 1'b1;
      step();
      ser_complete = 1'b0;
    end
    wait_idle("rr_idle");
    step();
    check("rr_done_count", W'(done_seen - base), W'(8));
    // COMPLETE already high when SEND is entered
    req_valid = 4'b0010;
    ser_complete = 1'b1;
    step();
    check("lvl_ack", W'(req_ack), W'(4'b0010));
    req_valid = '0;
    repeat (4) begin
      step();
      check("lvl_hold_ready", W'(ser_ready), W'(1));
      check("lvl_no_done", W'(frame_done), W'(0));
    end
    ser_complete = 1'b0;
    step();
    check("lvl_low_ready", W'(ser_ready), W'(1));
    ser_complete = 1'b1;
    step();
    ser_complete = 1'b0;
    check("lvl_done", W'(frame_done), W'(1));
    wait_idle("lvl_idle");
    // reset mid-SEND
    req_data = {rnd(), rnd(), rnd(), rnd()};
    req_valid = 4'b1000;
    step();
    check("abort_ack", W'(req_ack), W'(4'b1000));
    req_valid = 4'b1010;
    step();
    step();
    base = done_seen;
    rst_n = 1'b0;
    #1;
    check("abort_ready", W'(ser_ready), W'(0));
    check("abort_data", ser_data, W'(0));
    check("abort_busy", W'(busy), W'(0));
    check("abort_model_ready", W'(e_rdy), W'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_gid", W'(grant_id), W'(1));
    check("post_rst_ack", W'(req_ack), W'(4'b0010));
    check("abort_no_done", W'(done_seen - base), W'(0));
    req_valid = '0;
    ser_complete = 1'b1;
    step();
    ser_complete = 1'b0;
    wait_idle("abort_idle");
    // COMPLETE never rises
    base = done_seen;
    req_valid = 4'b0001;
    step();
    check("wd_ack", W'(req_ack), W'(4'b0001));
    req_valid = '0;
    repeat (20) step();
`ifdef OPENSERDES_SCHED_TIMEOUT_EN
    check("wd_err", W'(timeout_err), W'(1));
    check("wd_ready", W'(ser_ready), W'(0));
    check("wd_busy", W'(busy), W'(0));
    check("wd_no_done", W'(done_seen - base), W'(0));
`else
    check("wd_err", W'(timeout_err), W'(0));
    check("wd_ready", W'(ser_ready), W'(1));
    check("wd_busy", W'(busy), W'(1));
    ser_complete = 1'b1;
    step();
    ser_complete = 1'b0;
    wait_idle("wd_idle");
`endif
    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_ack[i] === 1'b1) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_data[W*i +: W] = rnd();
        end else if (req_valid[i] && $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) ser_complete = ~ser_complete;
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1;
    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/openserdes_tx_scheduler.md
OPENSERDES_TX_SCHEDULER -- requirements
Module: openserdes_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one serializer.
REQ-002 SHALL have parameter WIDTH, default 256, parallel word width (8 x 32-bit lanes).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles enforced between frames.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit (used only with the Configuration macro).
REQ-005 SHALL have port CLK  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port RESET  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port REQ_VALID  input  NUM_REQ  per-requester frame-pending flag.
REQ-008 SHALL have port REQ_DATA  input  NUM_REQ*WIDTH  per-requester word; slice i is [WIDTH*i +: WIDTH].
REQ-009 SHALL have port REQ_ACK  output  NUM_REQ  one-cycle, one-hot capture acknowledge.
REQ-010 SHALL have port SER_READY  output  1  drives serializer READY (input valid).
REQ-011 SHALL have port SER_DATA  output  WIDTH  drives serializer PAR_IN1..PAR_IN8; [31:0] goes to PAR_IN1.
REQ-012 SHALL have port SER_COMPLETE  input  1  serializer COMPLETE, synchronous to CLK.
REQ-013 SHALL have port GRANT_ID  output  $clog2(NUM_REQ)  index of the requester owning the current frame.
REQ-014 SHALL have port BUSY  output  1  high in SEND and GAP.
REQ-015 SHALL have port FRAME_DONE  output  1  one-cycle pulse on frame completion.
REQ-016 SHALL have port TIMEOUT_ERR  output  1  sticky watchdog flag.

Function
REQ-017 SHALL implement states IDLE, SEND and GAP.
REQ-018 IDLE: on any REQ_VALID bit set, SHALL grant round-robin, searching from last_grant+1 with wrap-around from NUM_REQ-1 to 0.
REQ-019 On grant at edge N, SHALL register SER_DATA and GRANT_ID, assert SER_READY, and pulse REQ_ACK[grant] during cycle N+1, then enter SEND.
REQ-020 Requesters SHALL hold REQ_VALID and REQ_DATA until REQ_ACK; a requester dropping REQ_VALID before grant is simply not granted.
REQ-021 SEND: SER_READY=1 and SER_DATA SHALL stay stable; leave only on a SER_COMPLETE rising edge (registered previous value is 0, current is 1).
REQ-022 A SER_COMPLETE level still high on entry to SEND SHALL NOT complete the frame; only a new rising edge counts.
REQ-023 On the completion edge, SHALL drop SER_READY the next cycle, pulse FRAME_DONE for one cycle, and enter GAP.
REQ-024 GAP: SHALL hold SER_READY=0 for exactly GAP_CYCLES cycles, then return to IDLE; GAP_CYCLES=0 SHALL go straight to IDLE.
REQ-025 REQ_VALID changes during SEND or GAP SHALL be ignored until IDLE; SER_COMPLETE edges in IDLE or GAP SHALL be ignored.
REQ-026 A requester re-requesting in IDLE SHALL NOT win twice in a row while another requester is pending.
REQ-027 SER_DATA SHALL be zero whenever the state is IDLE.

Reset
REQ-028 While RESET=0, SHALL force state IDLE, SER_READY=0, SER_DATA=0, REQ_ACK=0, GRANT_ID=0, BUSY=0, FRAME_DONE=0, TIMEOUT_ERR=0, and COMPLETE-edge register=0, asynchronously.
REQ-029 SHALL set last_grant to NUM_REQ-1 on reset so the first grant searches from requester 0.
REQ-030 Reset during SEND SHALL abort the frame with no REQ_ACK or FRAME_DONE; the aborted word is not retried.

Configuration
REQ-031 With OPENSERDES_SCHED_TIMEOUT_EN defined, SHALL count SEND cycles; reaching TIMEOUT_CYCLES without a completion edge SHALL set TIMEOUT_ERR, drop SER_READY, skip FRAME_DONE, and enter GAP.
REQ-032 TIMEOUT_ERR SHALL clear only on reset.
REQ-033 Without OPENSERDES_SCHED_TIMEOUT_EN, SHALL tie TIMEOUT_ERR to 0, add no counter, and wait in SEND indefinitely.

Verification
REQ-034 Only REQ_VALID[2] with data 0xA5..A5 -> REQ_ACK=4'b0100 for one cycle, GRANT_ID=2, SER_DATA=0xA5..A5 with SER_READY=1 until the COMPLETE edge.
REQ-035 All four REQ_VALID held for 8 frames -> grant order 0,1,2,3,0,1,2,3, with 8 FRAME_DONE pulses.
REQ-036 SER_COMPLETE held high across the SEND entry -> no completion until it falls and rises again.
REQ-037 GAP_CYCLES=2 -> exactly 2 cycles of SER_READY=0 between FRAME_DONE and the next SER_READY rise.
REQ-038 RESET=0 asserted mid-SEND -> SER_READY and SER_DATA at 0 immediately; after release the first grant goes to the lowest valid index.
REQ-039 With the macro defined, TIMEOUT_CYCLES=16 and COMPLETE never rising -> TIMEOUT_ERR=1 after 16 SEND cycles, then GAP then IDLE; without the macro, SEND is held.
